product_accum: RTL and testbench

PRODUCT_ACCUM -- requirements
Module: product_accum

---
 rtl/mult_pkg.sv | 15 +
 rtl/product_accum_dp.sv | 61 ++++++
 rtl/product_accum.sv | 97 +++++++++
 tb/tb_product_accum.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the product accumulator.
// Optional max tracking is enabled with macro PRODUCT_ACCUM_MAX_EN.
package mult_pkg;

  localparam int unsigned BLOCK_LEN_DEFAULT = 64;
  localparam int unsigned SUM_EXT           = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } accum_state_t;

endpackage

// File: rtl/product_accum_dp.sv
// Sum / max / count datapath driven by load, add and clear strobes.
// Max register and compare exist only when PRODUCT_ACCUM_MAX_EN is defined.
module product_accum_dp
  import mult_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEFAULT,
  localparam int unsigned SUM_W    = N + SUM_EXT,
  localparam int unsigned CNT_W    = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic             clear_i,
  input  logic [N-1:0]     data_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [N-1:0]     max_o,
  output logic [CNT_W-1:0] count_o
);

  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  // Load starts a new block; add extends it. Zero-extension keeps the sum exact.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sum_q <= SUM_W'(data_i);
      cnt_q <= CNT_W'(1);
    end else if (add_i) begin
      sum_q <= sum_q + SUM_W'(data_i);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef PRODUCT_ACCUM_MAX_EN
  logic [N-1:0] max_q;

  // Strict greater-than so ties keep the current value.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      max_q <= '0;
    end else if (load_i) begin
      max_q <= data_i;
    end else if (add_i && (data_i > max_q)) begin
      max_q <= data_i;
    end
  end

  assign max_o = max_q;
`else
  assign max_o = '0;
`endif

  assign sum_o   = sum_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/product_accum.sv
// Requests a block of product words, sums them and tracks the max, then hands off the result.
// Max tracking is built only with PRODUCT_ACCUM_MAX_EN defined; otherwise max_out is 0.
module product_accum
  import mult_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 rst,
  output logic                 EN_blockRead,
  input  logic                 VALID_memVal,
  input  logic [N-1:0]         memVal_data,
  output logic [N+SUM_EXT-1:0] sum_out,
  output logic [N-1:0]         max_out,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 err_unexp
);

  localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);

  accum_state_t     state_q, state_d;
  logic             en_q, rv_q, err_q, err_d;
  logic             load, add, clear;
  logic [CNT_W-1:0] count;

  // State and registered control outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == REQ);
      rv_q    <= (state_d == DONE);
      err_q   <= err_d;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    load    = 1'b0;
    add     = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (VALID_memVal) err_d = 1'b1;
      end
      REQ: begin
        if (VALID_memVal) begin
          load    = 1'b1;
          state_d = (BLOCK_LEN == 1) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (VALID_memVal) begin
          add = 1'b1;
          if (count == CNT_W'(BLOCK_LEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (VALID_memVal) err_d = 1'b1;
        if (result_ready) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  product_accum_dp #(
    .N         (N),
    .BLOCK_LEN (BLOCK_LEN)
  ) u_dp (
    .clk_i   (CLK),
    .rst_i   (rst),
    .load_i  (load),
    .add_i   (add),
    .clear_i (clear),
    .data_i  (memVal_data),
    .sum_o   (sum_out),
    .max_o   (max_out),
    .count_o (count)
  );

  assign EN_blockRead = en_q;
  assign result_valid = rv_q;
  assign err_unexp    = err_q;

endmodule

// File: tb/tb_product_accum.sv
// Directed self-checking bench for product_accum (default N=32, BLOCK_LEN=64).
module tb_product_accum;

  logic        CLK = 1'b0;
  logic        rst;
  logic        EN_blockRead;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic [37:0] sum_out;
  logic [31:0] max_out;
  logic        result_valid;
  logic        result_ready;
  logic        err_unexp;

  int checks = 0;
  int failures = 0;

`ifdef PRODUCT_ACCUM_MAX_EN
  localparam bit MAX_ON = 1'b1;
`else
  localparam bit MAX_ON = 1'b0;
`endif

  product_accum dut (
    .CLK          (CLK),
    .rst          (rst),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .sum_out      (sum_out),
    .max_out      (max_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err_unexp    (err_unexp)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int mode, input int i);
    case (mode)
      0:       return 32'(i);
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(65 - i);
      default: return 32'd2;
    endcase
  endfunction

  function automatic logic [31:0] exp_max(input logic [31:0] v);
    return MAX_ON ? v : 32'd0;
  endfunction

  // Waits (bounded) for a request, then feeds n words with an optional valid gap.
  task automatic run_block(input string tag, input int mode, input int n,
                           input int gap_after, input int gap_len, output int steps);
    int waited = 0;
    steps = 0;
    while (EN_blockRead !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_req_seen"}, 64'(EN_blockRead), 64'd1);
    for (int i = 1; i <= n; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = word(mode, i);
      step();
      steps++;
      if (i == 1) chk({tag, "_req_dropped"}, 64'(EN_blockRead), 64'd0);
      if (i == gap_after) begin
        VALID_memVal = 1'b0;
        memVal_data  = 32'h0;
        repeat (gap_len) begin
          step();
          steps++;
        end
      end
    end
    VALID_memVal = 1'b0;
    memVal_data  = 32'h0;
  endtask

  initial begin
    int steps;
    rst          = 1'b1;
    VALID_memVal = 1'b0;
    memVal_data  = 32'h0;
    result_ready = 1'b1;
    repeat (3) step();
    chk("rst_en",  64'(EN_blockRead), 64'd0);
    chk("rst_rv",  64'(result_valid), 64'd0);
    chk("rst_err", 64'(err_unexp), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_max", 64'(max_out), 64'd0);

    rst = 1'b0;
    step();
    chk("idle_to_req", 64'(EN_blockRead), 64'd1);
    step();
    step();
    chk("req_held", 64'(EN_blockRead), 64'd1);

    // Block A: 1..64 continuous
    run_block("A", 0, 64, 0, 0, steps);
    chk("A_latency", 64'(steps), 64'd64);
    chk("A_rv", 64'(result_valid), 64'd1);
    chk("A_sum", 64'(sum_out), 64'd2080);
    chk("A_max", 64'(max_out), 64'(exp_max(32'd64)));
    step();
    chk("A_rv_one_cycle", 64'(result_valid), 64'd0);
    chk("A_idle_no_req", 64'(EN_blockRead), 64'd0);
    step();
    chk("A_next_req", 64'(EN_blockRead), 64'd1);
    chk("A_err", 64'(err_unexp), 64'd0);

    // Block B: all ones, no overflow
    run_block("B", 1, 64, 0, 0, steps);
    chk("B_rv", 64'(result_valid), 64'd1);
    chk("B_sum", 64'(sum_out), 64'h3F_FFFF_FFC0);
    chk("B_max", 64'(max_out), 64'(exp_max(32'hFFFF_FFFF)));
    step();

    // Block C: 3-cycle gap after word 10
    run_block("C", 0, 64, 10, 3, steps);
    chk("C_latency", 64'(steps), 64'd67);
    chk("C_rv", 64'(result_valid), 64'd1);
    chk("C_sum", 64'(sum_out), 64'd2080);
    step();

    // Block D: descending, consumer stalls, stray word in DONE
    result_ready = 1'b0;
    run_block("D", 2, 64, 0, 0, steps);
    chk("D_sum", 64'(sum_out), 64'd2080);
    chk("D_max", 64'(max_out), 64'(exp_max(32'd64)));
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        VALID_memVal = 1'b1;
        memVal_data  = 32'h55;
      end
      step();
      VALID_memVal = 1'b0;
      memVal_data  = 32'h0;
      chk("D_hold_rv", 64'(result_valid), 64'd1);
      chk("D_hold_sum", 64'(sum_out), 64'd2080);
    end
    chk("D_err", 64'(err_unexp), 64'd1);
    result_ready = 1'b1;
    step();
    chk("D_rv_drop", 64'(result_valid), 64'd0);
    chk("D_err_sticky", 64'(err_unexp), 64'd1);

    // Block E: aborted by reset after 30 words
    run_block("E", 0, 30, 0, 0, steps);
    chk("E_partial_sum", 64'(sum_out), 64'd465);
    rst = 1'b1;
    step();
    chk("E_rst_rv", 64'(result_valid), 64'd0);
    chk("E_rst_sum", 64'(sum_out), 64'd0);
    chk("E_rst_err", 64'(err_unexp), 64'd0);
    chk("E_rst_en", 64'(EN_blockRead), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("E_no_result", 64'(result_valid), 64'd0);

    // Block F: all twos after reset
    run_block("F", 3, 64, 0, 0, steps);
    chk("F_rv", 64'(result_valid), 64'd1);
    chk("F_sum", 64'(sum_out), 64'd128);
    chk("F_max", 64'(max_out), 64'(exp_max(32'd2)));
    chk("F_err", 64'(err_unexp), 64'd0);
    step();
    chk("F_done", 64'(result_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
